// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM states and
// the width/saturation value of the optional bounce statistics counters.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_e;

    localparam int            BNC_W   = 8;
    localparam logic [BNC_W-1:0] BNC_SAT = 8'hFF;

    // Saturating increment for the bounce counters: sticks at BNC_SAT.
    function automatic logic [BNC_W-1:0] sat_inc(input logic [BNC_W-1:0] v);
        return (v == BNC_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: SYNC_STAGES-deep synchroniser feeding a STABLE/WAIT
// FSM that only accepts a new level after it has held for DEBOUNCE_CYCLES
// consecutive cycles. When DEBOUNCE_STATS_EN is defined the channel also
// counts aborted debounce attempts in a saturating 8-bit counter.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sw_i,
    output logic             out_o,
    output logic             chg_o,
`ifdef DEBOUNCE_STATS_EN
    output logic [BNC_W-1:0] bnc_cnt_o,
`endif
    output logic             wait_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   chg_q, chg_d;

    // Shift the raw switch level through the synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end

    assign y = sync_q[SYNC_STAGES-1];

    // FSM, counter, accepted level and change flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state logic: a mismatch opens a WAIT window, a match inside it aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        chg_d   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (y != out_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (y == out_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    out_d   = y;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    chg_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_STATS_EN
    logic [BNC_W-1:0] bnc_q;

    // Count every WAIT that falls back to STABLE without accepting the level.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                 bnc_q <= '0;
        else if (state_q == ST_WAIT && y == out_q) bnc_q <= sat_inc(bnc_q);
    end

    assign bnc_cnt_o = bnc_q;
`endif

    assign out_o  = out_q;
    assign chg_o  = chg_q;
    assign wait_o = (state_q == ST_WAIT);

endmodule

// File: rtl/switch_debounce_pair.sv
// Operand input stage for the half adder: two identical debounce channels
// turn the raw toggle switches into clean a/b levels, plus a shared change
// strobe and an "operands settled" flag. Optional macro DEBOUNCE_STATS_EN
// exposes per-channel aborted-debounce counters.
module switch_debounce_pair
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sw_a_i,
    input  logic             sw_b_i,
    output logic             a_o,
    output logic             b_o,
    output logic             chg_o,
`ifdef DEBOUNCE_STATS_EN
    output logic [BNC_W-1:0] bnc_cnt_a_o,
    output logic [BNC_W-1:0] bnc_cnt_b_o,
`endif
    output logic             stable_o
);

    logic chgA, chgB;
    logic waitA, waitB;

    debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_i     (sw_a_i),
        .out_o    (a_o),
        .chg_o    (chgA),
`ifdef DEBOUNCE_STATS_EN
        .bnc_cnt_o(bnc_cnt_a_o),
`endif
        .wait_o   (waitA)
    );

    debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_i     (sw_b_i),
        .out_o    (b_o),
        .chg_o    (chgB),
`ifdef DEBOUNCE_STATS_EN
        .bnc_cnt_o(bnc_cnt_b_o),
`endif
        .wait_o   (waitB)
    );

    // Simultaneous updates on both channels collapse into one strobe.
    assign chg_o    = chgA | chgB;
    assign stable_o = ~(waitA | waitB);

endmodule

// File: tb/tb_switch_debounce_pair.sv
// Bench for switch_debounce_pair. Reference model works on run lengths: an
// output flips on the DEBOUNCE_CYCLES-th consecutive edge on which the
// synchronised input differs from it; a mismatch run ending early is a bounce.
module tb_switch_debounce_pair;

    localparam int S = 2;
    localparam int D = 8;

    logic       clk;
    logic       rst;
    logic       swA, swB;
    logic       aOut, bOut, chgOut, stableOut;
`ifdef DEBOUNCE_STATS_EN
    logic [7:0] bncA, bncB;
`endif

    switch_debounce_pair #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_a_i     (swA),
        .sw_b_i     (swB),
        .a_o        (aOut),
        .b_o        (bOut),
        .chg_o      (chgOut),
`ifdef DEBOUNCE_STATS_EN
        .bnc_cnt_a_o(bncA),
        .bnc_cnt_b_o(bncB),
`endif
        .stable_o   (stableOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int totalChecks = 0;
    int passCount   = 0;

    // Reference model state
    logic histA [S];
    logic histB [S];
    logic mA, mB, mChg;
    int   runA, runB, mBncA, mBncB;

    task automatic modelChannel(input logic sw, inout logic hist [S], inout logic m,
                                inout int run, inout int bnc, inout logic flip);
        logic ySeen;
        ySeen = hist[S-1];
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sw;
        flip = 1'b0;
        if (ySeen != m) begin
            run++;
            if (run == D) begin
                m    = ySeen;
                run  = 0;
                flip = 1'b1;
            end
        end else begin
            if (run > 0 && bnc < 255) bnc++;
            run = 0;
        end
    endtask

    task automatic modelStep();
        logic fA, fB;
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                histA[i] = 1'b0;
                histB[i] = 1'b0;
            end
            mA = 0; mB = 0; mChg = 0;
            runA = 0; runB = 0; mBncA = 0; mBncB = 0;
        end else begin
            modelChannel(swA, histA, mA, runA, mBncA, fA);
            modelChannel(swB, histB, mB, runB, mBncB, fB);
            mChg = fA | fB;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        totalChecks++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic checkOutput();
        check("a",      {7'd0, aOut},      {7'd0, mA});
        check("b",      {7'd0, bOut},      {7'd0, mB});
        check("chg",    {7'd0, chgOut},    {7'd0, mChg});
        check("stable", {7'd0, stableOut}, {7'd0, (runA == 0 && runB == 0)});
`ifdef DEBOUNCE_STATS_EN
        check("bnc_cnt_a", bncA, 8'(mBncA));
        check("bnc_cnt_b", bncB, 8'(mBncB));
`endif
    endtask

    // Drive inputs just after an edge, then run n edges comparing against the model.
    task automatic applyStimulus(input logic sa, input logic sb, input logic r, input int n);
        swA = sa;
        swB = sb;
        rst = r;
        repeat (n) begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput();
        end
    endtask

    initial begin
        logic ra, rb, rr;
        swA = 1'b1; swB = 1'b1; rst = 1'b1;

        // Reset with both switches held high, then release
        applyStimulus(1, 1, 1, 3);
        check("reset_a_low", {7'd0, aOut}, 8'd0);
        check("reset_stable_high", {7'd0, stableOut}, 8'd1);
        applyStimulus(1, 1, 0, 9);
        check("a_before_edge10", {7'd0, aOut}, 8'd0);
        applyStimulus(1, 1, 0, 1);
        check("a_at_edge10", {7'd0, aOut}, 8'd1);
        check("chg_at_edge10", {7'd0, chgOut}, 8'd1);
        applyStimulus(1, 1, 0, 3);

        // Return to zero, then clean sw_a rise
        applyStimulus(0, 0, 0, 14);
        applyStimulus(1, 0, 0, 2);
        check("stable_before_edge3", {7'd0, stableOut}, 8'd1);
        applyStimulus(1, 0, 0, 1);
        check("stable_falls_edge3", {7'd0, stableOut}, 8'd0);
        applyStimulus(1, 0, 0, 12);

        // Five one-cycle glitches on sw_a from a settled 0
        applyStimulus(0, 0, 0, 14);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 14);
        check("glitch_a_low", {7'd0, aOut}, 8'd0);

        // Both channels rising together
        applyStimulus(1, 1, 0, 14);
        applyStimulus(0, 0, 0, 14);

        // sw_b rise interrupted by a one-cycle reset
        applyStimulus(0, 1, 0, 5);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 14);

        // 300 aborted debounces on sw_b to saturate its bounce counter
        applyStimulus(0, 0, 0, 14);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 6);

        // Randomised bouncing with occasional resets
        ra = 0; rb = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) ra = ~ra;
            if ($urandom_range(0, 4) == 0) rb = ~rb;
            rr = ($urandom_range(0, 299) == 0);
            applyStimulus(ra, rb, rr, 1);
            if ($urandom_range(0, 19) == 0) applyStimulus(ra, rb, 0, $urandom_range(8, 14));
        end

        $display("[TB] %0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
